// File: rtl/trng_conditioner.sv
// rtl/trng_conditioner.sv - RCT/APT health-tested entropy packer with word FIFO and trngio delivery
// Optional von Neumann debiaser ahead of the packer: define TRNG_VN_DEBIAS_EN.
module trng_conditioner #(
  parameter int TRNG_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int RCT_CUTOFF   = 32,
  parameter int APT_WINDOW   = 512,
  parameter int APT_CUTOFF   = 410,
  parameter int STARTUP_BITS = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          raw_bit,
  input  logic                          raw_valid,
  input  logic                          trng_req,
  output logic [TRNG_WIDTH-1:0]         trng_word,
  output logic                          trng_valid,
  input  logic                          health_clr,
  output logic                          health_fail,
  output logic                          src_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int RCW = $clog2(RCT_CUTOFF + 1);
  localparam int ACW = $clog2(APT_WINDOW + 1);
  localparam int SCW = $clog2(STARTUP_BITS + 1);
  localparam int BCW = (TRNG_WIDTH > 1) ? $clog2(TRNG_WIDTH) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;

  typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_FAIL} state_t;
  state_t state, state_next;

  logic [RCW-1:0]        rct_cnt, rct_next;
  logic                  prev_bit;
  logic [ACW-1:0]        apt_pos, apt_pos_next, apt_cnt, apt_next;
  logic                  apt_ref, apt_first;
  logic [SCW-1:0]        startup_cnt;
  logic [TRNG_WIDTH-1:0] pack_word, word_fill;
  logic [BCW-1:0]        pack_cnt;
  logic [TRNG_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [LW-1:0]         level;
  logic test_en, test_fail, startup_done, run_bit, pack_en, pack_bit, word_done, push, pop;

  assign test_en = raw_valid && (state != ST_FAIL);

  // rct_cnt == 0 marks "no previous bit" after reset or clear
  always_comb begin
    rct_next = rct_cnt;
    if (rct_cnt == '0 || raw_bit != prev_bit) rct_next = RCW'(1);
    else if (int'(rct_cnt) != RCT_CUTOFF)     rct_next = rct_cnt + 1'b1;
    apt_first    = (apt_pos == '0);
    apt_next     = apt_first ? ACW'(1) : ((raw_bit == apt_ref) ? apt_cnt + 1'b1 : apt_cnt);
    apt_pos_next = (int'(apt_pos) == APT_WINDOW - 1) ? '0 : apt_pos + 1'b1;
  end

  assign test_fail    = test_en && (int'(rct_next) == RCT_CUTOFF || int'(apt_next) == APT_CUTOFF);
  assign startup_done = test_en && !test_fail && (state == ST_STARTUP) &&
                        (int'(startup_cnt) == STARTUP_BITS - 1);
  assign run_bit      = test_en && !test_fail && (state == ST_RUN);

`ifdef TRNG_VN_DEBIAS_EN
  logic vn_phase, vn_first;
  assign pack_en  = run_bit && vn_phase && (vn_first != raw_bit);
  assign pack_bit = vn_first;

  always_ff @(posedge clk) begin
    if (reset || state != ST_RUN) begin
      vn_phase <= 1'b0;
      vn_first <= 1'b0;
    end else if (run_bit) begin
      vn_phase <= !vn_phase;
      if (!vn_phase) vn_first <= raw_bit;
    end
  end
`else
  assign pack_en  = run_bit;
  assign pack_bit = raw_bit;
`endif

  always_comb begin
    word_fill           = pack_word;
    word_fill[pack_cnt] = pack_bit;
  end

  assign word_done  = pack_en && (int'(pack_cnt) == TRNG_WIDTH - 1);
  assign pop        = trng_req && (level != '0) && (state != ST_FAIL);
  assign push       = word_done && ((level != LW'(FIFO_DEPTH)) || pop);
  assign fifo_level = level;

  always_comb begin
    state_next  = state;
    health_fail = (state == ST_FAIL);
    src_ready   = (state == ST_RUN);
    case (state)
      ST_STARTUP: if (test_fail) state_next = ST_FAIL;
                  else if (startup_done) state_next = ST_RUN;
      ST_RUN:     if (test_fail) state_next = ST_FAIL;
      ST_FAIL:    if (health_clr) state_next = ST_STARTUP;
      default:    state_next = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_STARTUP;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || (state == ST_FAIL && health_clr)) begin
      rct_cnt     <= '0;
      prev_bit    <= 1'b0;
      apt_pos     <= '0;
      apt_ref     <= 1'b0;
      apt_cnt     <= '0;
      startup_cnt <= '0;
    end else if (test_en) begin
      rct_cnt  <= rct_next;
      prev_bit <= raw_bit;
      apt_pos  <= apt_pos_next;
      apt_cnt  <= apt_next;
      if (apt_first) apt_ref <= raw_bit;
      if (state == ST_STARTUP) startup_cnt <= startup_cnt + 1'b1;
    end
  end

  // A failing bit flushes the FIFO and discards the partial word
  always_ff @(posedge clk) begin
    if (reset || test_fail) begin
      pack_word <= '0;
      pack_cnt  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
    end else begin
      if (pack_en) begin
        pack_word <= word_done ? '0 : word_fill;
        pack_cnt  <= word_done ? '0 : pack_cnt + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_fill;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trng_valid <= 1'b0;
      trng_word  <= '0;
    end else begin
      trng_valid <= pop;
      if (pop) trng_word <= mem[rd_ptr];
    end
  end
endmodule

// File: doc/trng_conditioner.md
Name: trng_conditioner

Overview:
Entropy front-end between the ring-oscillator sampler and the SoC `trngio` peripheral. It takes raw TRNG bits and runs SP 800-90B-style health tests on them: a repetition count test (RCT) and an adaptive proportion test (APT). Bits that pass are packed into TRNG_WIDTH-bit words and buffered in a small FIFO. Words are delivered on the SoC's `trng_req` / `trng_word` / `trng_valid` interface.

Parameters:
- TRNG_WIDTH, 4: output word width in bits; must be ≥1 and match the SoC TRNG_WIDTH.
- FIFO_DEPTH, 4: number of buffered words; power of 2, ≥2.
- RCT_CUTOFF, 32: RCT fails when the run of identical raw bits reaches this length.
- APT_WINDOW, 512: APT window length in raw bits.
- APT_CUTOFF, 410: APT fails when reference-bit occurrences in one window reach this count.
- STARTUP_BITS, 1024: number of raw bits that must be tested and discarded before RUN.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- raw_bit, in, 1: raw entropy bit from the sampler.
- raw_valid, in, 1: raw_bit is valid this cycle; one bit per asserted cycle.
- trng_req, in, 1: level request from trngio.
- trng_word, out, TRNG_WIDTH: delivered word.
- trng_valid, out, 1: one-cycle strobe; trng_word is valid.
- health_clr, in, 1: pulse that leaves FAIL and restarts STARTUP.
- health_fail, out, 1: sticky health-test failure flag.
- src_ready, out, 1: high in RUN state.
- fifo_level, out, clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high.
- State after reset:
  - State = STARTUP.
  - All counters, shift register and FIFO cleared.
  - trng_word = 0, trng_valid = 0, health_fail = 0, src_ready = 0, fifo_level = 0.
- States:
  - STARTUP: health tests run on every raw bit; bits are not packed. Startup counter increments per raw bit. After STARTUP_BITS bits with no failure, go to RUN.
  - RUN: tests run; bits are packed.
  - FAIL: entered from STARTUP or RUN on any test failure.
    - FIFO flushed, partial word cleared.
    - health_fail = 1, no deliveries.
    - Raw bits ignored.
    - health_clr → STARTUP with all test counters cleared. health_fail drops on the same edge.
    - health_clr outside FAIL is ignored.
- RCT:
  - On a raw bit equal to the previous bit, the run counter increments, saturating. On a different bit, the counter is set to 1. The first bit after reset or clear sets it to 1.
  - Fail when the counter value after update equals RCT_CUTOFF.
- APT:
  - The first bit of each window is the reference, and the count is set to 1.
  - Each later bit in the window equal to the reference increments the count.
  - Fail when the count after update equals APT_CUTOFF.
  - The window closes after APT_WINDOW bits; the next raw bit starts a new window.
- Failure timing: FAIL is registered on the clock edge that samples the failing bit. A failing bit is never packed.
- Packing:
  - In RUN, raw bits shift in LSB-first: the first bit lands in trng_word[0].
  - After TRNG_WIDTH bits the word is pushed to the FIFO and the bit counter wraps to 0.
  - If the FIFO is full and no pop occurs that cycle, the completed word is dropped and packing continues.
  - Push and pop in the same cycle on a full FIFO are both accepted; the level is unchanged.
- Delivery:
  - Each cycle, trng_valid is registered as (trng_req && FIFO non-empty && state != FAIL).
  - When trng_valid is set, the FIFO head is loaded into trng_word and popped in that same cycle.
  - Latency: 1 cycle from trng_req with a non-empty FIFO to trng_valid.
  - Holding trng_req delivers back-to-back words until the FIFO is empty.
  - trng_word holds its last value when trng_valid = 0.
  - A pushed word can be delivered at the earliest on the cycle after its push.
- Reset mid-operation: returns everything to the reset state within the same cycle, including any partial word and pending output.

Optional Feature:
- Macro: TRNG_VN_DEBIAS_EN.
- Defined: a von Neumann debiaser sits between the health tests and the packer.
  - Raw bits pass through the debiaser in pairs (a, b): 01 emits 0, 10 emits 1, 00 and 11 emit nothing.
  - Health tests always see every raw bit.
  - Pair phase resets on reset, health_clr and entry to RUN.
- Undefined: every RUN raw bit is packed directly.

Test Plan:
1. Startup gating and first delivery: reset, then STARTUP_BITS alternating 0/1 bits; then 4 more bits 1,0,1,1; trng_req = 1.
   - src_ready rises after bit 1024.
   - Then trng_valid = 1 for one cycle with trng_word = 4'b1101.
2. RCT failure: in RUN, 32 consecutive 1 bits.
   - health_fail = 1 on the edge sampling bit 32; fifo_level = 0; no further trng_valid.
   - health_clr → STARTUP, health_fail = 0.
3. APT failure: APT_CUTOFF = 10, APT_WINDOW = 16, RCT_CUTOFF large; window pattern 1,1,0,1,1,0,1,1,0,1,1,0,1,1 (1-bits at positions 1,2,4,5,7,8,10,11,13,14).
   - health_fail asserts on window bit 14 (the 10th one).
4. FIFO full and overflow:
   - Fill 4 words with trng_req = 0, then push a 5th word: fifo_level stays 4 and the 5th word is dropped.
   - Then trng_req = 1: 4 back-to-back trng_valid pulses with the first four words in order.
5. Reset mid-word: reset after 2 of 4 bits of a word.
   - All outputs return to their reset values.
   - No word appears after the next STARTUP completes until 4 fresh bits arrive.
6. With TRNG_VN_DEBIAS_EN: raw pairs 01,10,11,10,00,01 after startup.
   - Word packed = 0,1,1,0 LSB-first, i.e. trng_word = 4'b0110.
